// File: rtl/cl_ddr_scrb_pkg.sv
// cl_ddr_scrb_pkg: scrubber FSM states, AXI encodings and burst sizing helper
package cl_ddr_scrb_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_64B = 3'b110;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic logic [63:0] burst_bytes(input logic [7:0] len_m1);
    return (64'(len_m1) + 64'd1) << 6;
  endfunction
endpackage

// File: rtl/cl_ddr_scrb_pat.sv
// cl_ddr_scrb_pat: address-tagged write pattern, built only with SCRB_PATTERN_EN
`ifdef SCRB_PATTERN_EN
module cl_ddr_scrb_pat (
  input  logic [63:0]  addr,
  input  logic [7:0]   beat,
  output logic [511:0] wdata
);
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign wdata[i*64 +: 64] = addr + (64'(beat) << 6) + 64'(i * 8);
  end
endmodule
`endif

// File: rtl/cl_ddr_scrb.sv
// cl_ddr_scrb: AXI4 write-only DDR scrubber, one burst in flight; SCRB_PATTERN_EN selects patterned wdata
module cl_ddr_scrb
  import cl_ddr_scrb_pkg::*;
#(
  parameter logic [63:0] MAX_ADDR = 64'h3FFFFFFFF,
  parameter int BURST_LEN_MINUS1 = 15,
  parameter logic [15:0] AXI_ID = 16'h0
) (
  input  logic         clk_main_a0,
  input  logic         rst_main,
  input  logic         scrb_enable,
  output logic         scrb_busy,
  output logic         scrb_done,
  output logic         scrb_err,
  output logic [63:0]  scrb_addr,
  output logic [15:0]  cl_sh_ddr_awid,
  output logic [63:0]  cl_sh_ddr_awaddr,
  output logic [7:0]   cl_sh_ddr_awlen,
  output logic [2:0]   cl_sh_ddr_awsize,
  output logic [1:0]   cl_sh_ddr_awburst,
  output logic         cl_sh_ddr_awvalid,
  input  logic         sh_cl_ddr_awready,
  output logic [511:0] cl_sh_ddr_wdata,
  output logic [63:0]  cl_sh_ddr_wstrb,
  output logic         cl_sh_ddr_wlast,
  output logic         cl_sh_ddr_wvalid,
  input  logic         sh_cl_ddr_wready,
  input  logic [15:0]  sh_cl_ddr_bid,
  input  logic [1:0]   sh_cl_ddr_bresp,
  input  logic         sh_cl_ddr_bvalid,
  output logic         cl_sh_ddr_bready
);
  localparam logic [7:0] LEN = 8'(BURST_LEN_MINUS1);
  localparam logic [63:0] BB = burst_bytes(LEN);
  state_t state, nxt;
  logic [7:0] beat;
  logic [64:0] next_sum;
  logic last, unused_bid;
  assign unused_bid = ^sh_cl_ddr_bid;
  // 65-bit sum so a burst ending near 2^64 terminates instead of wrapping
  assign next_sum = {1'b0, scrb_addr} + {1'b0, BB};
  assign last = next_sum > {1'b0, MAX_ADDR};
  assign cl_sh_ddr_awid = AXI_ID;
  assign cl_sh_ddr_awaddr = scrb_addr;
  assign cl_sh_ddr_awlen = LEN;
  assign cl_sh_ddr_awsize = SIZE_64B;
  assign cl_sh_ddr_awburst = BURST_INCR;
  assign cl_sh_ddr_awvalid = state == ADDR;
  assign cl_sh_ddr_wvalid = state == DATA;
  assign cl_sh_ddr_wlast = state == DATA && beat == LEN;
  assign cl_sh_ddr_wstrb = '1;
  assign cl_sh_ddr_bready = state == RESP;
  assign scrb_busy = state == ADDR || state == DATA || state == RESP;
  assign scrb_done = state == DONE;
`ifdef SCRB_PATTERN_EN
  cl_ddr_scrb_pat u_pat (.addr(scrb_addr), .beat(beat), .wdata(cl_sh_ddr_wdata));
`else
  assign cl_sh_ddr_wdata = '0;
`endif
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = scrb_enable ? ADDR : IDLE;
      ADDR: nxt = sh_cl_ddr_awready ? DATA : ADDR;
      DATA: nxt = sh_cl_ddr_wready && cl_sh_ddr_wlast ? RESP : DATA;
      RESP: nxt = !sh_cl_ddr_bvalid ? RESP : !scrb_enable ? IDLE : last ? DONE : ADDR;
      DONE: nxt = scrb_enable ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state <= IDLE;
      scrb_addr <= '0;
      beat <= '0;
      scrb_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && scrb_enable) begin
        scrb_addr <= '0;
        scrb_err <= 1'b0;
      end
      if (state == DATA && sh_cl_ddr_wready) beat <= cl_sh_ddr_wlast ? '0 : beat + 8'd1;
      if (state == RESP && sh_cl_ddr_bvalid) begin
        if (sh_cl_ddr_bresp != RESP_OKAY) scrb_err <= 1'b1;
        if (nxt == ADDR) scrb_addr <= next_sum[63:0];
      end
    end
  end
endmodule

// File: tb/tb_cl_ddr_scrb.sv
// tb_cl_ddr_scrb: directed checks of cl_ddr_scrb with a small AXI slave and handshake monitor
module tb_cl_ddr_scrb;
  logic clk = 0, rst = 1, enable = 0;
  logic busy, done, err;
  logic [63:0] saddr, awaddr;
  logic [15:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic awvalid, awready = 1;
  logic [511:0] wdata;
  logic [63:0] wstrb;
  logic wlast, wvalid, wready, bready, bvalid = 1;
  logic w_fix = 1, w_toggle = 0, tog = 0;
  int aw_cnt = 0, w_cnt = 0, wl_cnt = 0, b_cnt = 0, bib = 0, err_burst = -1;
  bit ovl = 0, wl_bad = 0, nz = 0;
  logic [63:0] lane0 = 0, lane7 = 0;
  logic [63:0] aw_q[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(negedge clk) tog = ~tog;
  assign wready = w_toggle ? tog : w_fix;
  assign bresp = (aw_cnt == err_burst) ? 2'b10 : 2'b00;

  cl_ddr_scrb #(.MAX_ADDR(64'h1FFF)) dut (
    .clk_main_a0(clk), .rst_main(rst), .scrb_enable(enable),
    .scrb_busy(busy), .scrb_done(done), .scrb_err(err), .scrb_addr(saddr),
    .cl_sh_ddr_awid(awid), .cl_sh_ddr_awaddr(awaddr), .cl_sh_ddr_awlen(awlen),
    .cl_sh_ddr_awsize(awsize), .cl_sh_ddr_awburst(awburst), .cl_sh_ddr_awvalid(awvalid),
    .sh_cl_ddr_awready(awready), .cl_sh_ddr_wdata(wdata), .cl_sh_ddr_wstrb(wstrb),
    .cl_sh_ddr_wlast(wlast), .cl_sh_ddr_wvalid(wvalid), .sh_cl_ddr_wready(wready),
    .sh_cl_ddr_bid(16'h0), .sh_cl_ddr_bresp(bresp), .sh_cl_ddr_bvalid(bvalid),
    .cl_sh_ddr_bready(bready)
  );

  always @(posedge clk) begin
    if (rst) bib <= 0;
    else begin
      if (awvalid && wvalid) ovl <= 1;
      if (wlast && !wvalid) wl_bad <= 1;
      if (awvalid && awready) begin
        aw_cnt <= aw_cnt + 1;
        aw_q.push_back(awaddr);
      end
      if (wvalid && wready) begin
        w_cnt <= w_cnt + 1;
        bib <= wlast ? 0 : bib + 1;
        if (wlast != (bib == 15)) wl_bad <= 1;
        if (wlast) wl_cnt <= wl_cnt + 1;
        if (|wdata) nz <= 1;
        if (saddr == 64'h400 && bib == 1) begin
          lane0 <= wdata[63:0];
          lane7 <= wdata[511:448];
        end
      end
      if (bvalid && bready) b_cnt <= b_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    chk(tag, done, 1);
  endtask

  initial begin
    int b_aw, b_w, b_wl, b_b;
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", saddr, 0);

    // full scrub, all ready
    rst = 0;
    enable = 1;
    b_aw = aw_cnt; b_w = w_cnt; b_wl = wl_cnt;
    @(negedge clk);
    chk("addr_busy", busy, 1);
    chk("addr_awvalid", awvalid, 1);
    chk("addr_awaddr", awaddr, 0);
    chk("addr_awlen", awlen, 15);
    chk("addr_awsize", awsize, 3'b110);
    chk("addr_awburst", awburst, 2'b01);
    chk("addr_awid", awid, 0);
    chk("addr_wstrb", wstrb, '1);
    wait_done("full_done");
    chk("full_aw_cnt", aw_cnt - b_aw, 8);
    chk("full_beats", w_cnt - b_w, 128);
    chk("full_wlast_cnt", wl_cnt - b_wl, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("full_awaddr%0d", k), aw_q[b_aw + k], 64'(k) * 64'h400);
    chk("full_final_addr", saddr, 64'h1C00);
    chk("full_err", err, 0);
    chk("done_busy", busy, 0);
`ifdef SCRB_PATTERN_EN
    chk("pat_lane0", lane0, 64'h440);
    chk("pat_lane7", lane7, 64'h478);
`else
    chk("wdata_zero", nz, 0);
`endif
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    enable = 0;
    @(negedge clk);
    chk("done_exit", done, 0);

    // AW stall then W throttled every other cycle
    awready = 0;
    enable = 1;
    b_aw = aw_cnt; b_w = w_cnt; b_wl = wl_cnt;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_awvalid%0d", k), awvalid, 1);
      chk($sformatf("stall_awaddr%0d", k), awaddr, 0);
      chk($sformatf("stall_wvalid%0d", k), wvalid, 0);
      @(negedge clk);
    end
    chk("stall_beats", w_cnt - b_w, 0);
    awready = 1;
    w_toggle = 1;
    wait_done("tog_done");
    chk("tog_aw_cnt", aw_cnt - b_aw, 8);
    chk("tog_beats", w_cnt - b_w, 128);
    chk("tog_wlast_cnt", wl_cnt - b_wl, 8);
    w_toggle = 0;
    enable = 0;
    @(negedge clk);

    // error response on the third burst
    err_burst = aw_cnt + 3;
    enable = 1;
    b_aw = aw_cnt;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = (aw_cnt - b_aw) == 5;
    end
    chk("err_reach_b5", hit, 1);
    chk("err_set", err, 1);
    chk("err_not_done", done, 0);
    wait_done("err_done");
    chk("err_sticky", err, 1);
    chk("err_aw_cnt", aw_cnt - b_aw, 8);
    err_burst = -1;
    enable = 0;
    @(negedge clk);
    chk("err_idle_keeps", err, 1);

    // enable loss during DATA of burst 2
    enable = 1;
    b_aw = aw_cnt; b_w = w_cnt; b_wl = wl_cnt; b_b = b_cnt;
    @(negedge clk);
    chk("restart_err_clr", err, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (aw_cnt - b_aw) == 2 && wvalid;
    end
    chk("drop_reach_b2", hit, 1);
    enable = 0;
    @(negedge clk);
    chk("drop_wvalid_held", wvalid, 1);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("drop_idle", busy, 0);
    chk("drop_done", done, 0);
    chk("drop_aw_cnt", aw_cnt - b_aw, 2);
    chk("drop_beats", w_cnt - b_w, 32);
    chk("drop_wlast_cnt", wl_cnt - b_wl, 2);
    chk("drop_b_cnt", b_cnt - b_b, 2);
    enable = 1;
    @(negedge clk);
    chk("reen_awvalid", awvalid, 1);
    chk("reen_awaddr", awaddr, 0);

    // reset mid-burst
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = wvalid;
    end
    chk("rstmid_reach_data", hit, 1);
    rst = 1;
    @(negedge clk);
    chk("rstmid_wvalid", wvalid, 0);
    chk("rstmid_awvalid", awvalid, 0);
    chk("rstmid_bready", bready, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", saddr, 0);
    chk("ovl_never", ovl, 0);
    chk("wlast_placement", wl_bad, 0);
    rst = 0;
    enable = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
